// File: rtl/my_clipper_encode.sv
// Avalon-ST packet encoder for the clipper output side.
// Pops {sop, eop, pixel} words from a show-ahead FIFO and re-frames each frame
// as a control packet (width/height/interlace nibbles) then a video packet,
// through a single registered output stage with ready/valid back-pressure.
module my_clipper_encode #(
    parameter int DATA_WIDTH   = 24,
    parameter int COLOR_BITS   = 8,
    parameter int COLOR_PLANES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           im_width,
    input  logic [15:0]           im_height,
    input  logic [3:0]            im_interlaced,
    input  logic [DATA_WIDTH+1:0] fifo_q,
    input  logic                  fifo_empty,
    output logic                  fifo_rdreq,
    output logic [DATA_WIDTH-1:0] dout_data,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  dout_startofpacket,
    output logic                  dout_endofpacket
);

    typedef enum logic [2:0] {
        IDLE,
        CTRL_HDR,
        CTRL_DATA,
        DATA_HDR,
        DATA
    } state_t;

    localparam int unsigned PLANES = COLOR_PLANES;
    // Nine nibbles spread over PLANES nibbles per control word.
    localparam int unsigned NWORDS = (9 + PLANES - 1) / PLANES;

    state_t state, state_next;
    logic [3:0] cnt, cnt_next;
    logic [15:0] width_q, height_q;
    logic [3:0] interlaced_q;
    logic latch_en;

    logic load;
    logic avail;
    logic [DATA_WIDTH-1:0] word_data;
    logic word_sop, word_eop;
    logic [DATA_WIDTH-1:0] ctrl_data;
    logic [39:0] nibbles;

    logic fifo_sop, fifo_eop;
    logic [DATA_WIDTH-1:0] fifo_pixel;

    assign {fifo_sop, fifo_eop, fifo_pixel} = fifo_q;
    assign load = ~dout_valid | dout_ready;
    // Trailing zero nibble pads the last 2-plane word.
    assign nibbles = {width_q, height_q, interlaced_q, 4'h0};

    // Control word for the current count: nibble index cnt*PLANES+p into plane p.
    always_comb begin
        int unsigned idx;
        logic [39:0] sh;
        ctrl_data = '0;
        idx = 0;
        sh = '0;
        for (int unsigned p = 0; p < PLANES; p++) begin
            idx = 32'(cnt) * PLANES + p;
            sh = nibbles << (4 * idx);
            if (idx < 10)
                ctrl_data[p*COLOR_BITS +: 4] = sh[39:36];
        end
    end

    // Next-state, candidate output word and FIFO pop decision.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        latch_en   = 1'b0;
        fifo_rdreq = 1'b0;
        avail      = 1'b0;
        word_data  = '0;
        word_sop   = 1'b0;
        word_eop   = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    if (fifo_sop) begin
                        latch_en   = 1'b1;
                        state_next = CTRL_HDR;
                    end else begin
                        fifo_rdreq = load;
                    end
                end
            end
            CTRL_HDR: begin
                avail          = 1'b1;
                word_data[3:0] = 4'hF;
                word_sop       = 1'b1;
                if (load) begin
                    state_next = CTRL_DATA;
                    cnt_next   = '0;
                end
            end
            CTRL_DATA: begin
                avail     = 1'b1;
                word_data = ctrl_data;
                word_eop  = (cnt == 4'(NWORDS - 1));
                if (load) begin
                    cnt_next = cnt + 4'd1;
                    if (word_eop)
                        state_next = DATA_HDR;
                end
            end
            DATA_HDR: begin
                avail    = 1'b1;
                word_sop = 1'b1;
                if (load)
                    state_next = DATA;
            end
            DATA: begin
                avail     = !fifo_empty;
                word_data = fifo_pixel;
                word_eop  = fifo_eop;
                if (load && !fifo_empty) begin
                    fifo_rdreq = 1'b1;
                    if (fifo_eop)
                        state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (rst)
            fifo_rdreq = 1'b0;
    end

    // State, control word counter and frame parameter latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            width_q      <= '0;
            height_q     <= '0;
            interlaced_q <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (latch_en) begin
                width_q      <= im_width;
                height_q     <= im_height;
                interlaced_q <= im_interlaced;
            end
        end
    end

    // Output register: load a new word when empty or accepted, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_data          <= '0;
            dout_valid         <= 1'b0;
            dout_startofpacket <= 1'b0;
            dout_endofpacket   <= 1'b0;
        end else if (load) begin
            if (avail) begin
                dout_data          <= word_data;
                dout_valid         <= 1'b1;
                dout_startofpacket <= word_sop;
                dout_endofpacket   <= word_eop;
            end else begin
                dout_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_my_clipper_encode.sv
// Directed bench for my_clipper_encode: a 3-plane instance for framing,
// back-pressure, underrun, stray words and reset, plus a 1-plane instance.
module tb_my_clipper_encode;

    logic        clk;
    logic        rst;
    logic [15:0] im_width, im_height;
    logic [3:0]  im_interlaced;

    logic [25:0] fifo_q, fifo_q1;
    logic        fifo_empty, fifo_empty1;
    logic        fifo_rdreq, fifo_rdreq1;
    logic [23:0] dout_data, dout_data1;
    logic        dout_valid, dout_valid1;
    logic        dout_ready, dout_ready1;
    logic        dout_startofpacket, dout_startofpacket1;
    logic        dout_endofpacket, dout_endofpacket1;

    logic [25:0] q3[$], q1[$], out3[$], out1[$];
    int          acc_t3[$];
    int          cycle = 0;
    int          checks = 0;
    int          failures = 0;
    int          rd_count3 = 0;
    int          valid_seen3 = 0;
    bit          toggle = 0;

    my_clipper_encode #(.DATA_WIDTH(24), .COLOR_BITS(8), .COLOR_PLANES(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .im_width(im_width), .im_height(im_height), .im_interlaced(im_interlaced),
        .fifo_q(fifo_q), .fifo_empty(fifo_empty), .fifo_rdreq(fifo_rdreq),
        .dout_data(dout_data), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .dout_startofpacket(dout_startofpacket), .dout_endofpacket(dout_endofpacket)
    );

    my_clipper_encode #(.DATA_WIDTH(24), .COLOR_BITS(8), .COLOR_PLANES(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .im_width(im_width), .im_height(im_height), .im_interlaced(im_interlaced),
        .fifo_q(fifo_q1), .fifo_empty(fifo_empty1), .fifo_rdreq(fifo_rdreq1),
        .dout_data(dout_data1), .dout_valid(dout_valid1), .dout_ready(dout_ready1),
        .dout_startofpacket(dout_startofpacket1), .dout_endofpacket(dout_endofpacket1)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        fifo_empty  = (q3.size() == 0);
        fifo_q      = (q3.size() != 0) ? q3[0] : '0;
        fifo_empty1 = (q1.size() == 0);
        fifo_q1     = (q1.size() != 0) ? q1[0] : '0;
    endtask

    // One clock: sample away from the edge, then apply pops/accepts after it.
    task automatic tick();
        logic rd3, acc3, stall3, rd1, acc1;
        logic [25:0] beat3, beat1;
        rd3    = fifo_rdreq;
        acc3   = dout_valid && dout_ready && !rst;
        stall3 = dout_valid && !dout_ready && !rst;
        beat3  = {dout_startofpacket, dout_endofpacket, dout_data};
        rd1    = fifo_rdreq1;
        acc1   = dout_valid1 && dout_ready1 && !rst;
        beat1  = {dout_startofpacket1, dout_endofpacket1, dout_data1};
        if (rd3) begin
            check("rdreq_nonempty", fifo_empty, 0);
            rd_count3++;
        end
        if (rd1) check("rdreq1_nonempty", fifo_empty1, 0);
        if (stall3) check("stall_rdreq", rd3, 0);
        if (dout_valid === 1'b1) valid_seen3++;
        @(posedge clk);
        #1;
        if (stall3) check("stall_hold", {dout_startofpacket, dout_endofpacket, dout_data, dout_valid}, {beat3, 1'b1});
        if (rd3 && q3.size() > 0) void'(q3.pop_front());
        if (rd1 && q1.size() > 0) void'(q1.pop_front());
        if (acc3) begin
            out3.push_back(beat3);
            acc_t3.push_back(cycle);
        end
        if (acc1) out1.push_back(beat1);
        refresh();
        if (toggle) dout_ready = ~dout_ready;
        cycle++;
        #1;
    endtask

    task automatic push_pix3(input int i0, input int i1, input int total, input logic [23:0] base);
        logic s, e;
        for (int i = i0; i < i1; i++) begin
            s = (i == 0);
            e = (i == total - 1);
            q3.push_back({s, e, base + 24'(i)});
        end
        refresh();
        #1;
    endtask

    task automatic run_until3(input int n, input int budget);
        int b;
        b = budget;
        while (out3.size() < n && b > 0) begin
            tick();
            b--;
        end
        check("timeout3", out3.size(), n);
    endtask

    task automatic compare3(input string tag, input int npix, input logic [23:0] base);
        logic [25:0] ctl [5];
        logic [25:0] exp;
        ctl = '{26'h200000F, 26'h0080200, 26'h0010000, 26'h100000E, 26'h2000000};
        check({tag, "_len"}, out3.size(), 5 + npix);
        for (int i = 0; i < 5 && i < out3.size(); i++)
            check({tag, "_ctrl_beat"}, out3[i], ctl[i]);
        for (int i = 0; i < npix && 5 + i < out3.size(); i++) begin
            exp = {1'b0, (i == npix - 1), base + 24'(i)};
            check({tag, "_pixel_beat"}, out3[5+i], exp);
        end
    endtask

    initial begin
        logic [3:0]  nib [9];
        logic [25:0] exp;

        rst = 1;
        dout_ready = 1;
        dout_ready1 = 1;
        im_width = '0;
        im_height = '0;
        im_interlaced = '0;
        refresh();
        tick();
        tick();
        check("reset_data", dout_data, 0);
        check("reset_valid", dout_valid, 0);
        check("reset_sop", dout_startofpacket, 0);
        check("reset_eop", dout_endofpacket, 0);
        check("reset_rdreq", fifo_rdreq, 0);
        check("reset_valid1", dout_valid1, 0);
        rst = 0;
        #1;
        tick();

        // Basic 3-plane frame, sink always ready
        im_width = 16'd640;
        im_height = 16'd480;
        im_interlaced = 4'd0;
        out3.delete();
        acc_t3.delete();
        push_pix3(0, 6, 6, 24'hA00000);
        tick();
        check("hdr_latency_early", dout_valid, 0);
        tick();
        check("hdr_latency_valid", dout_valid, 1);
        check("hdr_latency_word", {dout_startofpacket, dout_endofpacket, dout_data}, 26'h200000F);
        run_until3(11, 40);
        compare3("t1", 6, 24'hA00000);
        check("t1_back_to_back", (acc_t3.size() == 11) ? acc_t3[10] - acc_t3[0] : -1, 10);

        // Back-pressure: ready toggles every cycle
        out3.delete();
        toggle = 1;
        push_pix3(0, 6, 6, 24'hB00000);
        run_until3(11, 80);
        toggle = 0;
        dout_ready = 1;
        #1;
        compare3("t2", 6, 24'hB00000);

        // Underrun: FIFO runs dry mid-frame for 5 cycles
        out3.delete();
        push_pix3(0, 3, 6, 24'hC00000);
        run_until3(8, 40);
        for (int k = 0; k < 5; k++) begin
            check("underrun_valid", dout_valid, 0);
            check("underrun_rdreq", fifo_rdreq, 0);
            tick();
        end
        push_pix3(3, 6, 6, 24'hC00000);
        tick();
        check("underrun_resume", {dout_valid, dout_data}, {1'b1, 24'hC00003});
        run_until3(11, 40);
        compare3("t3", 6, 24'hC00000);

        // Stray words in IDLE are discarded silently
        out3.delete();
        rd_count3 = 0;
        valid_seen3 = 0;
        q3.push_back(26'h0D00001);
        q3.push_back(26'h1D00002);
        q3.push_back(26'h0D00003);
        refresh();
        #1;
        repeat (6) tick();
        check("stray_pops", rd_count3, 3);
        check("stray_no_valid", valid_seen3, 0);
        check("stray_drained", q3.size(), 0);
        push_pix3(0, 4, 4, 24'hE00000);
        run_until3(9, 40);
        compare3("t4", 4, 24'hE00000);

        // Single plane instance, interlace nibble 3
        im_interlaced = 4'd3;
        out1.delete();
        q1.push_back({2'b10, 24'hF00000});
        q1.push_back({2'b01, 24'hF00001});
        refresh();
        #1;
        for (int b = 0; b < 50 && out1.size() < 13; b++) tick();
        check("t5_len", out1.size(), 13);
        nib = '{4'h0, 4'h2, 4'h8, 4'h0, 4'h0, 4'h1, 4'hE, 4'h0, 4'h3};
        if (out1.size() == 13) begin
            check("t5_hdr", out1[0], 26'h200000F);
            for (int i = 0; i < 9; i++) begin
                exp = {1'b0, (i == 8), 20'h0, nib[i]};
                check("t5_ctrl_word", out1[1+i], exp);
            end
            check("t5_data_hdr", out1[10], 26'h2000000);
            check("t5_pix0", out1[11], 26'h0F00000);
            check("t5_pix1", out1[12], 26'h1F00001);
        end

        // Reset in the middle of DATA
        im_interlaced = 4'd0;
        out3.delete();
        push_pix3(0, 6, 6, 24'h110000);
        run_until3(7, 40);
        q3.delete();
        refresh();
        rst = 1;
        #1;
        tick();
        rst = 0;
        #1;
        check("midrst_data", dout_data, 0);
        check("midrst_valid", dout_valid, 0);
        check("midrst_sop", dout_startofpacket, 0);
        check("midrst_eop", dout_endofpacket, 0);
        check("midrst_rdreq", fifo_rdreq, 0);
        tick();
        check("midrst_idle", dout_valid, 0);
        out3.delete();
        push_pix3(0, 3, 3, 24'h220000);
        tick();
        check("t6_hdr_early", dout_valid, 0);
        tick();
        check("t6_hdr_word", {dout_valid, dout_startofpacket, dout_endofpacket, dout_data}, 27'h600000F);
        run_until3(8, 40);
        compare3("t6", 3, 24'h220000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
